// File: rtl/n64adv2_vdemux_pkg.sv
// Shared constants for the N64 video demultiplexer: colour width, sync bit
// positions inside the sync word, and the demux state encoding.
package n64adv2_vdemux_pkg;

    localparam int color_width_i = 7;

    // Bit positions of the sync flags within the sync word on VD_i
    localparam int vsync_idx = 3;
    localparam int clamp_idx = 2;
    localparam int hsync_idx = 1;
    localparam int csync_idx = 0;

    typedef enum logic [1:0] {
        ST_WAIT_SYNC = 2'd0,
        ST_GET_R     = 2'd1,
        ST_GET_G     = 2'd2,
        ST_GET_B     = 2'd3
    } demux_state_t;

endpackage

// File: rtl/n64adv2_vinfo_fieldstat.sv
// Field statistics from the demultiplexed sync stream: counts lines per field
// on HSYNC falls, latches the count on VSYNC falls and decides PAL/NTSC and
// interlaced/progressive. Only words accompanied by i_valid are considered.
module n64adv2_vinfo_fieldstat
    import n64adv2_vdemux_pkg::*;
#(
    parameter int                    LCNT_WIDTH      = 10,
    parameter logic [LCNT_WIDTH-1:0] PAL_LINE_THRESH = LCNT_WIDTH'(288)
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_valid,
    input  logic                  i_hsync,
    input  logic                  i_vsync,
    output logic [LCNT_WIDTH-1:0] o_field_lines,
    output logic                  o_palmode,
    output logic                  o_interlaced,
    output logic                  o_vinfo_valid
);

    logic                  r_prev_hs;
    logic                  r_prev_vs;
    logic                  r_vs_seen;
    logic [LCNT_WIDTH-1:0] r_lcnt;
    logic                  w_hs_fall;
    logic                  w_vs_fall;
    logic [LCNT_WIDTH-1:0] w_lcnt_inc;

    assign w_hs_fall = i_valid & r_prev_hs & ~i_hsync;
    assign w_vs_fall = i_valid & r_prev_vs & ~i_vsync;

    // Line count including this word's HSYNC fall, saturating at all-ones;
    // a VSYNC fall in the same word latches this already-incremented value
    always_comb begin
        w_lcnt_inc = r_lcnt;
        if (w_hs_fall && (r_lcnt != '1))
            w_lcnt_inc = r_lcnt + LCNT_WIDTH'(1);
    end

    // Edge history, line counter and per-field decisions
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_prev_hs     <= 1'b0;
            r_prev_vs     <= 1'b0;
            r_vs_seen     <= 1'b0;
            r_lcnt        <= '0;
            o_field_lines <= '0;
            o_palmode     <= 1'b0;
            o_interlaced  <= 1'b0;
            o_vinfo_valid <= 1'b0;
        end else begin
            if (i_valid) begin
                r_prev_hs <= i_hsync;
                r_prev_vs <= i_vsync;
            end
            if (w_vs_fall) begin
                o_field_lines <= w_lcnt_inc;
                r_lcnt        <= '0;
                o_palmode     <= (w_lcnt_inc > PAL_LINE_THRESH);
                // The first fall closes a partial field; only the second
                // fall completes a full one and qualifies the statistics
                r_vs_seen     <= 1'b1;
                if (r_vs_seen)
                    o_vinfo_valid <= 1'b1;
                if (o_vinfo_valid)
                    o_interlaced <= (w_lcnt_inc != o_field_lines);
            end else begin
                r_lcnt <= w_lcnt_inc;
            end
        end
    end

endmodule

// File: rtl/n64adv2_vdemux.sv
// First PPU stage: demultiplexes the 4-word N64 video group (sync, R, G, B)
// into one parallel pixel with a 1-cycle valid strobe, flags misaligned
// nVDSYNC and derives field statistics from the emitted sync words.
module n64adv2_vdemux
    import n64adv2_vdemux_pkg::*;
#(
    parameter int                    LCNT_WIDTH      = 10,
    parameter logic [LCNT_WIDTH-1:0] PAL_LINE_THRESH = LCNT_WIDTH'(288)
) (
    input  logic                     N64_CLK_i,
    input  logic                     N64_nVRST_i,
    input  logic                     nVDSYNC_i,
    input  logic [color_width_i-1:0] VD_i,
    output logic                     vdata_valid_o,
    output logic [3:0]               vdata_sync_o,
    output logic [color_width_i-1:0] vdata_r_o,
    output logic [color_width_i-1:0] vdata_g_o,
    output logic [color_width_i-1:0] vdata_b_o,
    output logic                     resync_err_o,
    output logic [LCNT_WIDTH-1:0]    field_lines_o,
    output logic                     palmode_o,
    output logic                     interlaced_o,
    output logic                     vinfo_valid_o
);

    demux_state_t             r_state;
    demux_state_t             w_state_nxt;
    logic                     w_sync_cap;
    logic                     w_r_cap;
    logic                     w_g_cap;
    logic                     w_b_cap;
    logic                     w_resync;
    logic [3:0]               w_sync_word;
    logic [3:0]               r_sync_hold;
    logic [color_width_i-1:0] r_r_hold;
    logic [color_width_i-1:0] r_g_hold;

    assign w_sync_word = {VD_i[vsync_idx], VD_i[clamp_idx], VD_i[hsync_idx], VD_i[csync_idx]};

    // Next-state and capture decode; a sync word in any colour slot restarts the group
    always_comb begin
        w_state_nxt = r_state;
        w_sync_cap  = 1'b0;
        w_r_cap     = 1'b0;
        w_g_cap     = 1'b0;
        w_b_cap     = 1'b0;
        w_resync    = 1'b0;
        case (r_state)
            ST_WAIT_SYNC: begin
                if (!nVDSYNC_i) begin
                    w_sync_cap  = 1'b1;
                    w_state_nxt = ST_GET_R;
                end
            end
            ST_GET_R, ST_GET_G, ST_GET_B: begin
                if (!nVDSYNC_i) begin
                    w_resync    = 1'b1;
                    w_sync_cap  = 1'b1;
                    w_state_nxt = ST_GET_R;
                end else begin
                    w_r_cap     = (r_state == ST_GET_R);
                    w_g_cap     = (r_state == ST_GET_G);
                    w_b_cap     = (r_state == ST_GET_B);
                    w_state_nxt = (r_state == ST_GET_R) ? ST_GET_G :
                                  (r_state == ST_GET_G) ? ST_GET_B : ST_WAIT_SYNC;
                end
            end
            default: w_state_nxt = ST_WAIT_SYNC;
        endcase
    end

    // Demux state register
    always_ff @(posedge N64_CLK_i) begin
        if (!N64_nVRST_i)
            r_state <= ST_WAIT_SYNC;
        else
            r_state <= w_state_nxt;
    end

    // Holding registers and pixel outputs; all four channels update together on the B sample
    always_ff @(posedge N64_CLK_i) begin
        if (!N64_nVRST_i) begin
            r_sync_hold   <= 4'hF;
            r_r_hold      <= '0;
            r_g_hold      <= '0;
            vdata_valid_o <= 1'b0;
            vdata_sync_o  <= 4'hF;
            vdata_r_o     <= '0;
            vdata_g_o     <= '0;
            vdata_b_o     <= '0;
            resync_err_o  <= 1'b0;
        end else begin
            if (w_sync_cap) r_sync_hold <= w_sync_word;
            if (w_r_cap)    r_r_hold    <= VD_i;
            if (w_g_cap)    r_g_hold    <= VD_i;
            vdata_valid_o <= w_b_cap;
            resync_err_o  <= w_resync;
            if (w_b_cap) begin
                vdata_sync_o <= r_sync_hold;
                vdata_r_o    <= r_r_hold;
                vdata_g_o    <= r_g_hold;
                vdata_b_o    <= VD_i;
            end
        end
    end

    n64adv2_vinfo_fieldstat #(
        .LCNT_WIDTH      (LCNT_WIDTH),
        .PAL_LINE_THRESH (PAL_LINE_THRESH)
    ) u_fieldstat (
        .i_clk         (N64_CLK_i),
        .i_nrst        (N64_nVRST_i),
        .i_valid       (vdata_valid_o),
        .i_hsync       (vdata_sync_o[hsync_idx]),
        .i_vsync       (vdata_sync_o[vsync_idx]),
        .o_field_lines (field_lines_o),
        .o_palmode     (palmode_o),
        .o_interlaced  (interlaced_o),
        .o_vinfo_valid (vinfo_valid_o)
    );

endmodule

// File: tb/tb_n64adv2_vdemux.sv
// Directed bench for n64adv2_vdemux: pixel demux, resync handling,
// field statistics (NTSC/PAL, interlace, thresholds, saturation) and reset.
module tb_n64adv2_vdemux;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       nvdsync = 1'b1;
    logic [6:0] vd = '0;
    logic       vdata_valid;
    logic [3:0] vdata_sync;
    logic [6:0] vdata_r, vdata_g, vdata_b;
    logic       resync_err;
    logic [9:0] field_lines;
    logic       palmode, interlaced, vinfo_valid;

    int n_total = 0;
    int n_pass  = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int v0, e0;

    always #5 clk = ~clk;

    n64adv2_vdemux dut (
        .N64_CLK_i     (clk),
        .N64_nVRST_i   (nrst),
        .nVDSYNC_i     (nvdsync),
        .VD_i          (vd),
        .vdata_valid_o (vdata_valid),
        .vdata_sync_o  (vdata_sync),
        .vdata_r_o     (vdata_r),
        .vdata_g_o     (vdata_g),
        .vdata_b_o     (vdata_b),
        .resync_err_o  (resync_err),
        .field_lines_o (field_lines),
        .palmode_o     (palmode),
        .interlaced_o  (interlaced),
        .vinfo_valid_o (vinfo_valid)
    );

    // Pulse counters, sampled on the active edge (pre-update values)
    always @(posedge clk) begin
        if (vdata_valid) valid_cnt <= valid_cnt + 1;
        if (resync_err)  err_cnt   <= err_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic drive_word(input logic ns, input logic [6:0] w);
        @(negedge clk);
        nvdsync = ns;
        vd      = w;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_word(1'b1, 7'h00);
    endtask

    task automatic send_pixel(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g, input logic [6:0] b);
        drive_word(1'b0, {3'b000, s});
        drive_word(1'b1, r);
        drive_word(1'b1, g);
        drive_word(1'b1, b);
    endtask

    // One line = HSYNC high pixel then HSYNC low pixel; last line also drops VSYNC
    task automatic send_field(input int n);
        for (int i = 0; i < n; i++) begin
            send_pixel(4'hF, 7'h01, 7'h02, 7'h03);
            send_pixel((i == n - 1) ? 4'h5 : 4'hD, 7'h01, 7'h02, 7'h03);
        end
        idle(3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0; nvdsync = 1'b1; vd = '0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", vdata_valid, 0);
        check("rst_sync", vdata_sync, 4'hF);
        check("rst_rgb", {vdata_r, vdata_g, vdata_b}, 0);
        check("rst_err", resync_err, 0);
        check("rst_vinfo", {field_lines, palmode, interlaced, vinfo_valid}, 0);
        nrst = 1'b1;

        // Clean stream, 1-clk latency
        drive_word(1'b0, 7'h0F);
        drive_word(1'b1, 7'h11);
        drive_word(1'b1, 7'h22);
        drive_word(1'b1, 7'h33);
        check("clean_pre_valid", vdata_valid, 0);
        drive_word(1'b1, 7'h00);
        check("clean_valid", vdata_valid, 1);
        check("clean_rgb", {vdata_r, vdata_g, vdata_b}, {7'h11, 7'h22, 7'h33});
        check("clean_sync", vdata_sync, 4'hF);
        drive_word(1'b1, 7'h00);
        check("clean_strobe_1clk", vdata_valid, 0);
        check("clean_hold_rgb", {vdata_r, vdata_g, vdata_b}, {7'h11, 7'h22, 7'h33});

        // Misaligned nVDSYNC in GET_G
        v0 = valid_cnt; e0 = err_cnt;
        drive_word(1'b0, 7'h0A);
        drive_word(1'b1, 7'h10);
        drive_word(1'b0, 7'h0F);
        drive_word(1'b1, 7'h55);
        check("mis_err_pulse", resync_err, 1);
        check("mis_no_valid", vdata_valid, 0);
        drive_word(1'b1, 7'h66);
        check("mis_err_clear", resync_err, 0);
        drive_word(1'b1, 7'h77);
        drive_word(1'b1, 7'h00);
        check("mis_valid", vdata_valid, 1);
        check("mis_rgb", {vdata_r, vdata_g, vdata_b}, {7'h55, 7'h66, 7'h77});
        check("mis_sync", vdata_sync, 4'hF);
        idle(3);
        check("mis_err_cnt", err_cnt - e0, 1);
        check("mis_valid_cnt", valid_cnt - v0, 1);

        // NTSC progressive, 263 lines x 3 fields
        do_reset();
        send_field(263);
        check("ntsc_f1_lines", field_lines, 263);
        check("ntsc_f1_vinfo", vinfo_valid, 0);
        send_field(263);
        check("ntsc_f2_vinfo", vinfo_valid, 1);
        check("ntsc_f2_lines", field_lines, 263);
        send_field(263);
        check("ntsc_f3_lines", field_lines, 263);
        check("ntsc_f3_pal", palmode, 0);
        check("ntsc_f3_ilace", interlaced, 0);

        // PAL threshold boundary: 288 is NTSC, 289 is PAL
        do_reset();
        send_field(288);
        check("thr_288_pal", palmode, 0);
        send_field(289);
        check("thr_289_pal", palmode, 1);
        check("thr_289_ilace", interlaced, 0);
        send_field(288);
        check("thr_288b_pal", palmode, 0);
        check("thr_288b_ilace", interlaced, 1);

        // Simultaneous HSYNC+VSYNC fall after 262 counted lines
        do_reset();
        send_field(10);
        for (int i = 0; i < 262; i++) begin
            send_pixel(4'hF, 7'h00, 7'h00, 7'h00);
            send_pixel(4'hD, 7'h00, 7'h00, 7'h00);
        end
        send_pixel(4'hF, 7'h00, 7'h00, 7'h00);
        send_pixel(4'h5, 7'h00, 7'h00, 7'h00);
        idle(3);
        check("simul_lines", field_lines, 263);

        // Line counter saturation
        do_reset();
        send_field(2);
        send_field(1030);
        check("sat_lines", field_lines, 10'h3FF);
        check("sat_pal", palmode, 1);

        // PAL interlaced, 312/313 alternating
        do_reset();
        send_field(312);
        check("pal_f1_lines", field_lines, 312);
        check("pal_f1_vinfo", vinfo_valid, 0);
        send_field(313);
        check("pal_f2_lines", field_lines, 313);
        check("pal_f2_vinfo", vinfo_valid, 1);
        check("pal_f2_ilace", interlaced, 0);
        send_field(312);
        check("pal_f3_lines", field_lines, 312);
        check("pal_f3_pal", palmode, 1);
        check("pal_f3_ilace", interlaced, 1);
        send_field(313);
        check("pal_f4_lines", field_lines, 313);
        check("pal_f4_ilace", interlaced, 1);

        // Reset asserted in GET_B
        drive_word(1'b0, 7'h0F);
        drive_word(1'b1, 7'h44);
        drive_word(1'b1, 7'h45);
        @(negedge clk);
        nrst = 1'b0; nvdsync = 1'b1; vd = 7'h46;
        @(negedge clk);
        check("rstb_valid", vdata_valid, 0);
        check("rstb_sync", vdata_sync, 4'hF);
        check("rstb_rgb", {vdata_r, vdata_g, vdata_b}, 0);
        check("rstb_vinfo", {field_lines, palmode, interlaced, vinfo_valid}, 0);
        nrst = 1'b1; vd = 7'h00;
        v0 = valid_cnt; e0 = err_cnt;
        idle(5);
        check("rstb_no_valid", valid_cnt - v0, 0);
        check("rstb_no_err", err_cnt - e0, 0);
        drive_word(1'b0, 7'h0E);
        drive_word(1'b1, 7'h21);
        drive_word(1'b1, 7'h31);
        check("rstb_lat_pre", vdata_valid, 0);
        drive_word(1'b1, 7'h41);
        check("rstb_lat_b", vdata_valid, 0);
        drive_word(1'b1, 7'h00);
        check("rstb_lat_valid", vdata_valid, 1);
        check("rstb_pix", {vdata_sync, vdata_r, vdata_g, vdata_b}, {4'hE, 7'h21, 7'h31, 7'h41});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
